stage2_rstd: RTL

STAGE2_RSTD -- requirements
Module: stage2_rstd

---
 rtl/stage2_rstd.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/stage2_rstd.sv
// Computes variance and reciprocal standard deviation from E[x] and E[x^2],
// using a bit-serial square root followed by a bit-serial restoring division.
module stage2_rstd #(
    parameter int unsigned EPS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_S1_done,
    input  logic [21:0] i_Ex,
    input  logic [31:0] i_Ex2,
    output logic        o_ready_in,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [21:0] o_mean,
    output logic [31:0] o_var,
    output logic [23:0] o_rstd
);

    typedef enum logic [2:0] {StIdle, StVar, StSqrt, StDiv, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [21:0] mean_q;
    logic [31:0] ex2_q;
    logic [31:0] var_q;
    logic [23:0] rstd_q;
    logic        valid_q;
    logic [31:0] rad_q;
    logic [17:0] rem_q;
    logic [15:0] root_q;
    logic [24:0] dvd_q;
    logic [15:0] drem_q;
    logic [23:0] quo_q;

    logic [43:0] prod;
    logic        var_neg;
    logic [31:0] var_d;
    logic [32:0] v_sum;
    logic [31:0] v_clip;
    logic [19:0] rem_sh;
    logic [19:0] trial;
    logic        sq_ge;
    logic [19:0] rem_sub;
    logic [17:0] rem_d;
    logic [15:0] root_d;
    logic [16:0] drem_sh;
    logic        dv_ge;
    logic [16:0] drem_sub;
    logic [15:0] drem_d;
    logic [24:0] quo_d;
    logic [23:0] rstd_d;

    always_comb begin
        prod    = 44'(mean_q) * 44'(mean_q);
        // Negative variance clamps to zero; otherwise the low 32 bits are exact.
        var_neg = {12'd0, ex2_q} < prod;
        var_d   = var_neg ? 32'd0 : (ex2_q - prod[31:0]);
        v_sum   = {1'b0, var_d} + 33'(EPS);
        v_clip  = v_sum[32] ? 32'hFFFF_FFFF : v_sum[31:0];

        rem_sh  = {rem_q, rad_q[31:30]};
        trial   = {2'b00, root_q, 2'b01};
        sq_ge   = rem_sh >= trial;
        rem_sub = rem_sh - trial;
        rem_d   = sq_ge ? rem_sub[17:0] : rem_sh[17:0];
        root_d  = {root_q[14:0], sq_ge};

        // A zero divisor never subtracts; the result is forced to saturation below.
        drem_sh  = {drem_q, dvd_q[24]};
        dv_ge    = (root_q != 16'd0) && (drem_sh >= {1'b0, root_q});
        drem_sub = drem_sh - {1'b0, root_q};
        drem_d   = dv_ge ? drem_sub[15:0] : drem_sh[15:0];
        quo_d    = {quo_q, dv_ge};
        rstd_d   = ((root_q == 16'd0) || quo_d[24]) ? 24'hFF_FFFF : quo_d[23:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mean_q  <= '0;
            ex2_q   <= '0;
            var_q   <= '0;
            rstd_q  <= '0;
            valid_q <= 1'b0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            dvd_q   <= '0;
            drem_q  <= '0;
            quo_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_S1_done) begin
                        mean_q  <= i_Ex;
                        ex2_q   <= i_Ex2;
                        state_q <= StVar;
                    end
                end
                StVar: begin
                    var_q   <= var_d;
                    rad_q   <= v_clip;
                    rem_q   <= '0;
                    root_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= StSqrt;
                end
                StSqrt: begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    rad_q  <= {rad_q[29:0], 2'b00};
                    if (cnt_q == 5'd15) begin
                        cnt_q   <= '0;
                        drem_q  <= '0;
                        quo_q   <= '0;
                        dvd_q   <= 25'h100_0000;
                        state_q <= StDiv;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDiv: begin
                    drem_q <= drem_d;
                    quo_q  <= quo_d[23:0];
                    dvd_q  <= {dvd_q[23:0], 1'b0};
                    if (cnt_q == 5'd24) begin
                        cnt_q   <= '0;
                        rstd_q  <= rstd_d;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready_in = (state_q == StIdle);
    assign o_valid    = valid_q;
    assign o_mean     = mean_q;
    assign o_var      = var_q;
    assign o_rstd     = rstd_q;

endmodule
